// File: rtl/regfile_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_writer: 32 x WIDTH register array fed by a DEPTH-entry write      |
// | queue, with youngest-match forwarding of queued writes to the read port. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_writer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [4:0]               wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [4:0]               rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int         c_AW       = $clog2(DEPTH);
  localparam int         c_CW       = c_AW + 1;
  localparam logic [4:0] c_ZERO_REG = 5'd31;

  logic [WIDTH-1:0] r_regs  [32];
  logic [4:0]       r_qaddr [DEPTH];
  logic [WIDTH-1:0] r_qdata [DEPTH];
  logic [c_AW-1:0]  r_head;
  logic [c_AW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_fwd_hit;
  logic [WIDTH-1:0] w_fwd_data;
  logic [c_AW-1:0]  w_idx;

  // Ready is masked by reset so nothing is accepted while the block is held.
  assign wr_ready = reset & (r_count < c_CW'(DEPTH));
  assign w_push   = wr_valid & wr_ready;
  assign w_pop    = (r_count != '0);
  assign count    = r_count;
  assign idle     = (r_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qaddr[r_tail] <= wr_addr;
      r_qdata[r_tail] <= wr_data;
    end
  end

  // Head commits every cycle the queue is non-empty; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_pop && (r_qaddr[r_head] != c_ZERO_REG)) begin
      r_regs[r_qaddr[r_head]] <= r_qdata[r_head];
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + c_AW'(i);
      if ((c_CW'(i) < r_count) && (r_qaddr[w_idx] == rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_qdata[w_idx];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr == c_ZERO_REG) rd_data = '0;
    else if (w_fwd_hit)        rd_data = w_fwd_data;
    else                       rd_data = r_regs[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writer.sv
`default_nettype none
// tb_regfile_writer: queue-based reference model checked every cycle, plus literal expectations.
module tb_regfile_writer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       count;
  logic             idle;

  regfile_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t      m_q [$];
  bit [63:0] m_regs [32];
  int        n_cmp = 0;
  int        n_bad = 0;
  bit        chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes draining one per cycle into an array.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else begin
      automatic int sz = m_q.size();
      if (sz > 0) begin
        if (m_q[0].a != 5'd31) m_regs[m_q[0].a] <= m_q[0].d;
        void'(m_q.pop_front());
      end
      if (wr_valid && sz < DEPTH) m_q.push_back('{a: wr_addr, d: wr_data});
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].a == a) return m_q[i].d;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data", rd_data, exp_rd(rd_addr));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("idle", 64'(idle), 64'(m_q.size() == 0));
      chk("wr_ready", 64'(wr_ready), 64'(reset && (m_q.size() < DEPTH)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [4:0] a, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  task automatic stop_wr();
    wr_valid = 1'b0;
  endtask

  logic [63:0] exp20 [20];

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd", rd_data, 64'd0);
    reset = 1'b1;
    #1 chk("ready_after_rst", 64'(wr_ready), 64'd1);

    // Basic write and forwarded read
    rd_addr = 5'd5;
    put(5'd5, 64'hDEAD_BEEF_0000_0001);
    step(); stop_wr();
    chk("basic_fwd", rd_data, 64'hDEAD_BEEF_0000_0001);
    chk("basic_cnt1", 64'(count), 64'd1);
    step();
    chk("basic_cnt0", 64'(count), 64'd0);
    chk("basic_idle", 64'(idle), 64'd1);
    chk("basic_arr", rd_data, 64'hDEAD_BEEF_0000_0001);

    // Streaming writes never stall since one entry drains every cycle
    rd_addr = 5'd3;
    for (int i = 1; i <= 6; i++) begin
      put(5'(i), 64'(i));
      chk("stream_ready", 64'(wr_ready), 64'd1);
      step();
      chk("stream_cnt", 64'(count), 64'd1);
    end
    stop_wr(); step();
    chk("stream_drain", 64'(count), 64'd0);
    chk("stream_x3", rd_data, 64'd3);
    for (int i = 0; i < 4; i++) begin
      put(5'(8 + i), 64'h80 + 64'(i));
      chk("burst_ready", 64'(wr_ready), 64'd1);
      step();
    end
    stop_wr(); step();
    rd_addr = 5'd11; #1 chk("burst_x11", rd_data, 64'h83);

    // Same-address ordering
    step();
    rd_addr = 5'd7;
    put(5'd7, 64'd10); step(); chk("ord_10", rd_data, 64'd10);
    put(5'd7, 64'd20); step(); chk("ord_20", rd_data, 64'd20);
    put(5'd7, 64'd30); step(); chk("ord_30", rd_data, 64'd30);
    stop_wr(); step();
    chk("ord_final", rd_data, 64'd30);
    chk("ord_cnt", 64'(count), 64'd0);

    // Zero register
    rd_addr = 5'd31;
    put(5'd31, 64'hFFFF); step(); stop_wr();
    chk("x31_rd_q", rd_data, 64'd0);
    chk("x31_cnt1", 64'(count), 64'd1);
    step();
    chk("x31_rd_arr", rd_data, 64'd0);
    chk("x31_cnt0", 64'(count), 64'd0);

    // Reset mid-operation
    rd_addr = 5'd2;
    put(5'd2, 64'h22); step();
    put(5'd3, 64'h33); step();
    put(5'd4, 64'h44); step(); stop_wr();
    chk("mid_cnt_pre", 64'(count), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_cnt", 64'(count), 64'd0);
    chk("mid_ready", 64'(wr_ready), 64'd0);
    chk("mid_rd", rd_data, 64'd0);
    step(); step();
    reset = 1'b1;
    for (int a = 2; a <= 4; a++) begin
      rd_addr = 5'(a);
      #1 chk("mid_after", rd_data, 64'd0);
      step();
    end

    // Pointer wrap with 20 consecutive writes
    for (int i = 0; i < 20; i++) begin
      exp20[i] = {$urandom, $urandom};
      rd_addr = 5'($urandom_range(0, 31));
      put(5'(i), exp20[i]);
      step();
    end
    stop_wr(); step(); step();
    chk("wrap_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 20; i++) begin
      rd_addr = 5'(i);
      #1 chk("wrap_rd", rd_data, exp20[i]);
      step();
    end

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
